// File: rtl/sfx_pkg.sv
// Shared types and note tables for the sound-effect sequencer.
// Tone half-periods are built from these tables when the design is elaborated.
package sfx_pkg;

    typedef enum logic [1:0] {
        SFX_NONE     = 2'd0,
        SFX_CORRECT  = 2'd1,
        SFX_WRONG    = 2'd2,
        SFX_GAMEOVER = 2'd3
    } sfx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned HP_W  = 17;
    localparam int unsigned DUR_W = 9;

    localparam logic [DUR_W-1:0] GAP_MS = 9'd50;

    // Indexed [effect][note]; unused slots are zero.
    localparam int unsigned NOTE_HZ [4][4] = '{
        '{0,    0,   0,   0},
        '{1000, 0,   0,   0},
        '{200,  0,   0,   0},
        '{523,  392, 262, 0}
    };

    localparam logic [DUR_W-1:0] NOTE_MS [4][4] = '{
        '{9'd0,   9'd0,   9'd0,   9'd0},
        '{9'd100, 9'd0,   9'd0,   9'd0},
        '{9'd250, 9'd0,   9'd0,   9'd0},
        '{9'd200, 9'd200, 9'd300, 9'd0}
    };

    localparam logic [1:0] LAST_NOTE [4] = '{2'd0, 2'd0, 2'd0, 2'd2};

    typedef logic [3:0][3:0][HP_W-1:0] hp_tab_t;

    function automatic logic [HP_W-1:0] half_period(int unsigned clk_hz, int unsigned f);
        if (f == 0) begin
            return '0;
        end else begin
            return HP_W'(clk_hz / (2 * f));
        end
    endfunction

    function automatic hp_tab_t hp_table(int unsigned clk_hz);
        hp_tab_t t;
        for (int s = 0; s < 4; s++) begin
            for (int n = 0; n < 4; n++) begin
                t[s][n] = half_period(clk_hz, NOTE_HZ[s][n]);
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/square_wave_gen.sv
// Toggle divider: the wave flips every half_period cycles while run is high.
// clear returns the counter and the wave to zero so each note starts low.
module square_wave_gen #(
    parameter int unsigned W = 17
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] half_period,
    output logic         wave
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         wave_q, wave_d;

    // Next-state for the divider; a zero half-period holds the counter still.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (clear) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (run && (half_period != '0)) begin
            if (cnt_q >= half_period - W'(1)) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/sfx_player.sv
// Sound-effect sequencer: priority arbitration of game events, note/gap FSM,
// millisecond prescaler and duration counter driving one buzzer pin.
module sfx_player
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned MS_DIV = CLK_HZ / 1000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       correct_hit,
    input  logic       wrong_hit,
    input  logic       game_over_hit,
    input  logic       sound_en,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] cur_sfx
);

    localparam int unsigned PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam hp_tab_t     HP_TAB = hp_table(CLK_HZ);

    state_e             state_q, state_d;
    sfx_e               sfx_q, sfx_d, req_s;
    logic [1:0]         note_q, note_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]   dur_q, dur_d, limit_s;
    logic               busy_q, busy_d;
    logic               en_q;
    logic               tick_s, restart_s, clear_s, run_s, wave_s;
    logic [HP_W-1:0]    hp_s;

    assign tick_s  = (pre_q == PRE_W'(MS_DIV - 1));
    assign limit_s = (state_q == ST_GAP) ? GAP_MS : NOTE_MS[sfx_q][note_q];
    assign hp_s    = HP_TAB[sfx_q][note_q];

    // Request encoding follows enum order, so a numeric compare gives priority.
    always_comb begin
        if (game_over_hit) begin
            req_s = SFX_GAMEOVER;
        end else if (wrong_hit) begin
            req_s = SFX_WRONG;
        end else if (correct_hit) begin
            req_s = SFX_CORRECT;
        end else begin
            req_s = SFX_NONE;
        end
    end

    // Sequencer next-state: restart on accepted request, else step notes and gaps.
    always_comb begin
        state_d   = state_q;
        sfx_d     = sfx_q;
        note_d    = note_q;
        pre_d     = pre_q;
        dur_d     = dur_q;
        restart_s = 1'b0;
        if ((req_s != SFX_NONE) && (req_s >= sfx_q)) begin
            restart_s = 1'b1;
            state_d   = ST_TONE;
            sfx_d     = req_s;
            note_d    = 2'd0;
            pre_d     = '0;
            dur_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_TONE, ST_GAP: begin
                    if (tick_s) begin
                        pre_d = '0;
                        if (dur_q == limit_s - DUR_W'(1)) begin
                            dur_d = '0;
                            if (state_q == ST_GAP) begin
                                state_d = ST_TONE;
                                note_d  = note_q + 2'd1;
                            end else if (note_q == LAST_NOTE[sfx_q]) begin
                                state_d = ST_IDLE;
                                sfx_d   = SFX_NONE;
                                note_d  = 2'd0;
                            end else begin
                                state_d = ST_GAP;
                            end
                        end else begin
                            dur_d = dur_q + DUR_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sfx_d   = SFX_NONE;
                    note_d  = 2'd0;
                end
            endcase
        end
    end

    // Every state change also zeroes the divider so the buzzer drops with it.
    assign clear_s = restart_s || (state_d != state_q);
    assign run_s   = (state_q == ST_TONE);
    assign busy_d  = (state_d != ST_IDLE);

    // Sequencer state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sfx_q   <= SFX_NONE;
            note_q  <= 2'd0;
            pre_q   <= '0;
            dur_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sfx_q   <= sfx_d;
            note_q  <= note_d;
            pre_q   <= pre_d;
            dur_q   <= dur_d;
            busy_q  <= busy_d;
            en_q    <= sound_en;
        end
    end

    square_wave_gen #(.W(HP_W)) u_wave (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .clear       (clear_s),
        .run         (run_s),
        .half_period (hp_s),
        .wave        (wave_s)
    );

    assign buzzer  = wave_s & en_q;
    assign busy    = busy_q;
    assign cur_sfx = sfx_q;

endmodule
